pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default `WORD_LEN (32), sets the width of each payload field (PC, instruction).
REQ-002 Parameter CNT_W, default 16, sets the width of the bubble counter.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 flush  input  1  kills the stage contents.
REQ-006 freeze  input  1  stalls the stage from the hazard unit.
REQ-007 in_valid  input  1  upstream beat present.
REQ-008 in_ready  output  1  stage can accept a beat.
REQ-009 in_pc  input  DATA_W  upstream PC.
REQ-010 in_instr  input  DATA_W  upstream instruction.
REQ-011 out_valid  output  1  downstream beat present.
REQ-012 out_ready  input  1  downstream accepts the beat.
REQ-013 out_pc  output  DATA_W  registered PC.
REQ-014 out_instr  output  DATA_W  registered instruction.
REQ-015 stat_bubbles  output  CNT_W  bubble count; the port exists only with PIPE_STAGE_STATS_EN defined.

Function
REQ-016 The stage SHALL hold a 2-entry buffer (main + skid) controlled by an FSM with states EMPTY, ONE and FULL.
REQ-017 Accept = in_valid & in_ready & ~freeze; drain = out_valid & out_ready & ~freeze.
REQ-018 in_ready SHALL be registered: high in EMPTY and ONE, low in FULL, and forced low while freeze=1.
REQ-019 out_valid SHALL be high in ONE or FULL and forced low while freeze=1.
REQ-020 out_pc and out_instr SHALL always present the main entry.
REQ-021 EMPTY: accept loads main and moves to ONE; latency from accept edge to out_valid is 1 cycle.
REQ-022 ONE, accept without drain: load skid, go to FULL.
REQ-023 ONE, accept with drain: load main, stay in ONE.
REQ-024 ONE, drain without accept: go to EMPTY.
REQ-025 FULL, drain: move skid to main, go to ONE; no accept is possible in FULL.
REQ-026 With freeze=1, all state and payload registers SHALL hold, regardless of flush.
REQ-027 With flush=1 and freeze=0, the stage SHALL go to EMPTY, clear both entries to 0, and discard any same-cycle upstream beat.
REQ-028 Entering EMPTY by drain SHALL also clear the main entry to 0, so out_pc and out_instr read 0 whenever the stage is empty.
REQ-029 Beat order SHALL be preserved; no beat SHALL be duplicated or dropped except by flush.

Reset
REQ-030 Asserting rst (0) SHALL immediately force EMPTY, both entries and the bubble counter to 0, and in_ready to 1; this holds mid-operation, including in FULL.
REQ-031 Release SHALL be synchronised by the integrating top level; the block SHALL behave normally from the first edge after rst=1.

Configuration
REQ-032 Macro PIPE_STAGE_STATS_EN, when defined: stat_bubbles increments on each cycle with rst=1, freeze=0 and out_valid=0.
REQ-033 With the macro defined, stat_bubbles saturates at 2^CNT_W-1 and is cleared only by reset, not by flush.
REQ-034 Without the macro, the counter and the stat_bubbles port SHALL be absent, and the remaining behaviour SHALL be identical.

Structure
REQ-035 The state enum pipe_stage_state_t (EMPTY, ONE, FULL) and the payload struct pipe_payload_t {pc, instr} SHALL live in the shared package pipe_pkg, beside `WORD_LEN in defines.sv.
REQ-036 One sub-module, pipe_sat_counter (saturating counter, CNT_W), SHALL be instantiated only under PIPE_STAGE_STATS_EN.

Verification
REQ-037 Reset mid-FULL: rst=0 -> same cycle out_valid=0, in_ready=1, out_pc=0, out_instr=0.
REQ-038 Back-pressure: push pc=0x10, then 0x14, then 0x18 with out_ready=0 -> state FULL, in_ready=0, 0x18 held upstream; then out_ready=1 -> outputs 0x10, 0x14, 0x18 in order, no loss.
REQ-039 Streaming: in_valid=1 and out_ready=1 for 8 cycles -> out_valid stays 1 after the 1-cycle latency, and 8 beats emerge in order.
REQ-040 Flush in FULL with in_valid=1 (instr=0xDEADBEEF) -> next cycle EMPTY, out_instr=0, and 0xDEADBEEF never appears at the output.
REQ-041 freeze=1 together with flush=1 while holding pc=0x20 -> contents retained; after freeze=0, out_pc=0x20 and out_valid=1.
REQ-042 With PIPE_STAGE_STATS_EN and CNT_W=4: 20 idle unfrozen cycles -> stat_bubbles=15 (saturated); flush leaves it at 15.

Source files
------------

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline stage types (state enum, payload struct)
`ifndef WORD_LEN
`define WORD_LEN 32
`endif

package pipe_pkg;

   localparam int WORD_W = `WORD_LEN;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } pipe_stage_state_t;

   typedef struct packed {
      logic [WORD_W-1:0] pc;
      logic [WORD_W-1:0] instr;
   } pipe_payload_t;

endpackage

// File: rtl/defines.sv
// rtl/defines.sv - project-wide word length
`ifndef WORD_LEN
`define WORD_LEN 32
`endif

// File: rtl/pipe_sat_counter.sv
// rtl/pipe_sat_counter.sv - saturating up-counter, cleared only by reset
module pipe_sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (en && (count != {CNT_W{1'b1}})) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - skid-buffered pipeline stage with flush/freeze
// Optional bubble statistics when PIPE_STAGE_STATS_EN is defined.
`ifndef WORD_LEN
`define WORD_LEN 32
`endif

module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int DATA_W = `WORD_LEN,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              freeze,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_pc,
   input  logic [DATA_W-1:0] in_instr,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_pc,
   output logic [DATA_W-1:0] out_instr
`ifdef PIPE_STAGE_STATS_EN
   ,
   output logic [CNT_W-1:0]  stat_bubbles
`endif
);

   pipe_stage_state_t state_q, state_d;
   logic              rdy_q;
   logic [DATA_W-1:0] main_pc_q, main_pc_d, main_instr_q, main_instr_d;
   logic [DATA_W-1:0] skid_pc_q, skid_pc_d, skid_instr_q, skid_instr_d;
   logic              accept, drain;

   assign in_ready  = rdy_q & ~freeze;
   assign out_valid = (state_q != EMPTY) & ~freeze;
   assign out_pc    = main_pc_q;
   assign out_instr = main_instr_q;
   assign accept    = in_valid & in_ready & ~freeze;
   assign drain     = out_valid & out_ready & ~freeze;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= EMPTY;
         rdy_q        <= 1'b1;
         main_pc_q    <= '0;
         main_instr_q <= '0;
         skid_pc_q    <= '0;
         skid_instr_q <= '0;
      end else begin
         state_q      <= state_d;
         rdy_q        <= (state_d != FULL);
         main_pc_q    <= main_pc_d;
         main_instr_q <= main_instr_d;
         skid_pc_q    <= skid_pc_d;
         skid_instr_q <= skid_instr_d;
      end
   end

   // Freeze dominates flush: nothing moves while the hazard unit stalls us.
   always_comb begin
      state_d      = state_q;
      main_pc_d    = main_pc_q;
      main_instr_d = main_instr_q;
      skid_pc_d    = skid_pc_q;
      skid_instr_d = skid_instr_q;
      if (!freeze) begin
         if (flush) begin
            state_d      = EMPTY;
            main_pc_d    = '0;
            main_instr_d = '0;
            skid_pc_d    = '0;
            skid_instr_d = '0;
         end else begin
            case (state_q)
               EMPTY: begin
                  if (accept) begin
                     state_d      = ONE;
                     main_pc_d    = in_pc;
                     main_instr_d = in_instr;
                  end
               end
               ONE: begin
                  if (accept && !drain) begin
                     state_d      = FULL;
                     skid_pc_d    = in_pc;
                     skid_instr_d = in_instr;
                  end else if (accept && drain) begin
                     main_pc_d    = in_pc;
                     main_instr_d = in_instr;
                  end else if (drain) begin
                     state_d      = EMPTY;
                     main_pc_d    = '0;
                     main_instr_d = '0;
                  end
               end
               FULL: begin
                  if (drain) begin
                     state_d      = ONE;
                     main_pc_d    = skid_pc_q;
                     main_instr_d = skid_instr_q;
                     skid_pc_d    = '0;
                     skid_instr_d = '0;
                  end
               end
               default: state_d = EMPTY;
            endcase
         end
      end
   end

`ifdef PIPE_STAGE_STATS_EN
   pipe_sat_counter #(
      .CNT_W (CNT_W)
   ) u_bubbles (
      .clk   (clk),
      .rst   (rst),
      .en    (~freeze & ~out_valid),
      .count (stat_bubbles)
   );
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - self-checking bench for pipe_stage_reg
module tb_pipe_stage_reg;

   localparam int DW = 32;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          flush = 1'b0;
   logic          freeze = 1'b0;
   logic          in_valid = 1'b0;
   logic          out_ready = 1'b0;
   logic [DW-1:0] in_pc = '0;
   logic [DW-1:0] in_instr = '0;
   logic          in_ready, out_valid;
   logic [DW-1:0] out_pc, out_instr;
`ifdef PIPE_STAGE_STATS_EN
   logic [CW-1:0] stat_bubbles;
`endif

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   pipe_stage_reg #(
      .DATA_W (DW),
      .CNT_W  (CW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .freeze    (freeze),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_pc     (in_pc),
      .in_instr  (in_instr),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_pc    (out_pc),
      .out_instr (out_instr)
`ifdef PIPE_STAGE_STATS_EN
      ,
      .stat_bubbles (stat_bubbles)
`endif
   );

   typedef struct {
      logic [DW-1:0] pc;
      logic [DW-1:0] instr;
   } beat_t;

   beat_t m_q[$];
   beat_t obs[$];
   logic  m_rdy = 1'b1;
   int    m_bub = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: an ordered queue of at most two beats plus a registered ready flag.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_q.delete();
         m_rdy <= 1'b1;
         m_bub <= 0;
      end else if (!freeze) begin
         if (m_q.size() == 0 && m_bub < (1 << CW) - 1) m_bub <= m_bub + 1;
         if (flush) begin
            m_q.delete();
         end else begin
            if (m_q.size() > 0 && out_ready) void'(m_q.pop_front());
            if (in_valid && m_rdy) m_q.push_back('{in_pc, in_instr});
         end
         m_rdy <= (m_q.size() < 2);
      end
   end

   always @(negedge clk) begin
      check("out_valid", 32'(out_valid), 32'(m_q.size() > 0 && !freeze));
      check("in_ready", 32'(in_ready), 32'(m_rdy && !freeze));
      check("out_pc", out_pc, (m_q.size() > 0) ? m_q[0].pc : 32'h0);
      check("out_instr", out_instr, (m_q.size() > 0) ? m_q[0].instr : 32'h0);
`ifdef PIPE_STAGE_STATS_EN
      check("stat_bubbles", 32'(stat_bubbles), 32'(m_bub));
`endif
      if (out_valid && out_ready) obs.push_back('{out_pc, out_instr});
   end

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   initial begin
      #1 rst = 1'b0;
      cyc();
      cyc();
      check("rst_out_valid", 32'(out_valid), 32'h0);
      check("rst_in_ready", 32'(in_ready), 32'h1);
      check("rst_out_pc", out_pc, 32'h0);
      rst = 1'b1;
      cyc();

      // back-pressure: three pushes against a stalled consumer
      obs.delete();
      out_ready = 1'b0;
      in_valid = 1'b1; in_pc = 32'h10; in_instr = 32'hA0; cyc();
      in_pc = 32'h14; in_instr = 32'hA1; cyc();
      in_pc = 32'h18; in_instr = 32'hA2; cyc();
      check("bp_in_ready", 32'(in_ready), 32'h0);
      check("bp_out_pc", out_pc, 32'h10);
      out_ready = 1'b1; cyc(); cyc();
      in_valid = 1'b0; cyc(); cyc();
      check("bp_count", obs.size(), 32'd3);
      if (obs.size() == 3) begin
         check("bp_beat0", obs[0].pc, 32'h10);
         check("bp_beat1", obs[1].pc, 32'h14);
         check("bp_beat2", obs[2].pc, 32'h18);
      end

      // streaming
      obs.delete();
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1; in_pc = 32'h100 + 32'(4 * i); in_instr = ~in_pc;
         cyc();
         check("st_out_valid", 32'(out_valid), 32'h1);
      end
      in_valid = 1'b0; cyc(); cyc();
      check("st_count", obs.size(), 32'd8);
      for (int i = 0; i < obs.size() && i < 8; i++)
         check("st_order", obs[i].pc, 32'h100 + 32'(4 * i));

      // asynchronous reset while FULL
      out_ready = 1'b0;
      in_valid = 1'b1; in_pc = 32'h40; in_instr = 32'h4040; cyc();
      in_pc = 32'h44; in_instr = 32'h4444; cyc();
      in_valid = 1'b0;
      check("full_in_ready", 32'(in_ready), 32'h0);
      rst = 1'b0;
      #1;
      check("mid_rst_out_valid", 32'(out_valid), 32'h0);
      check("mid_rst_in_ready", 32'(in_ready), 32'h1);
      check("mid_rst_out_pc", out_pc, 32'h0);
      check("mid_rst_out_instr", out_instr, 32'h0);
      cyc();
      rst = 1'b1;
      cyc();

      // flush in FULL with an upstream beat present
      obs.delete();
      out_ready = 1'b0;
      in_valid = 1'b1; in_pc = 32'h30; in_instr = 32'h1111; cyc();
      in_pc = 32'h34; in_instr = 32'h2222; cyc();
      in_pc = 32'h38; in_instr = 32'hDEADBEEF; flush = 1'b1; cyc();
      check("fl_out_instr", out_instr, 32'h0);
      check("fl_out_valid", 32'(out_valid), 32'h0);
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      cyc(); cyc(); cyc();
      begin
         int seen = 0;
         foreach (obs[i]) if (obs[i].instr == 32'hDEADBEEF) seen++;
         check("fl_dead_seen", 32'(seen), 32'h0);
      end

      // freeze overrides flush
      obs.delete();
      out_ready = 1'b0;
      in_valid = 1'b1; in_pc = 32'h20; in_instr = 32'h5555; cyc();
      in_pc = 32'h24; in_instr = 32'h6666; freeze = 1'b1; flush = 1'b1; cyc(); cyc();
      check("fz_out_valid", 32'(out_valid), 32'h0);
      freeze = 1'b0; flush = 1'b0; in_valid = 1'b0;
      #1;
      check("fz_out_pc", out_pc, 32'h20);
      check("fz_out_valid_after", 32'(out_valid), 32'h1);
      out_ready = 1'b1; cyc(); cyc();
      check("fz_count", obs.size(), 32'd1);

`ifdef PIPE_STAGE_STATS_EN
      rst = 1'b0; cyc(); rst = 1'b1;
      out_ready = 1'b0; in_valid = 1'b0;
      repeat (20) cyc();
      check("bub_sat", 32'(stat_bubbles), 32'd15);
      flush = 1'b1; cyc(); flush = 1'b0; cyc();
      check("bub_after_flush", 32'(stat_bubbles), 32'd15);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
